// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// mem_op_t : ALU-supplied memory operation (2'b11 is reserved and behaves like MEM_NONE).
// state_t  : bus sequencer state.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  // Flag bit set in wb_rflags when a bus transaction is aborted by timeout.
  localparam int MEM_ERR_FLAG_BIT = 31;

  // True for operations that need a bus transaction. The reserved encoding
  // falls through to a plain register write.
  function automatic logic is_mem_access(input logic [1:0] op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait watchdog: counts cycles spent waiting for bus_ack.
// Latency: expire is combinational in the LIMIT-th counted cycle.
// Backpressure: none; clear has priority over count.
//
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clear      : restart the count (a new instruction was captured)
//   count      : this cycle is a bus-wait cycle
//   expire     : high during the LIMIT-th consecutive counted cycle
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expire
);

  // Values 0..LIMIT-1 must be representable.
  localparam int unsigned CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CNT_W-1:0] cnt;

  // cnt holds the index of the current wait cycle, so the LIMIT-th cycle
  // sees cnt == LIMIT-1 and aborts on that edge.
  assign expire = count && (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: takes ALU results, runs an optional load/store on the data bus, hands off to writeback.
// Latency: 1 cycle for non-memory ops; 2+ cycles for load/store (ack in first bus cycle gives 2).
// Backpressure: mem_blocked stalls the ALU while a bus access is outstanding or a writeback entry is stalled.
//
// Optional feature macro: MEM_TIMEOUT_EN (bus-wait timeout, adds TIMEOUT_CYC parameter and bus_err output).
//
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   exe_mem, alu_result, alu_rflags, mem_op, store_data, dst_reg : instruction from the ALU
//   mem_blocked           : stall back to the ALU
//   bus_req, bus_we, bus_addr, bus_wdata, bus_ack, bus_rdata     : request/acknowledge data bus
//   wb_valid, wb_we, wb_data, wb_rflags, wb_dst, wb_blocked      : writeback handoff
//   bus_err               : (MEM_TIMEOUT_EN only) one-cycle pulse when a bus access times out
module mem_stage
  import mem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int REG_W  = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic              clk,
  input  logic              reset,
  // ALU side
  input  logic              exe_mem,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [31:0]       alu_rflags,
  input  logic [1:0]        mem_op,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  dst_reg,
  output logic              mem_blocked,
  // data bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  // writeback side
  output logic              wb_valid,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_rflags,
  output logic [REG_W-1:0]  wb_dst,
  input  logic              wb_blocked
`ifdef MEM_TIMEOUT_EN
  , output logic            bus_err
`endif
);

  state_t state;
  state_t state_nxt;

  // Per-instruction context kept while the bus access is in flight. The
  // address, store flag and store data already live in the bus_* registers.
  logic [31:0]      lat_rflags;
  logic [REG_W-1:0] lat_dst;

  logic cap;       // instruction accepted from the ALU this edge
  logic cap_mem;   // ... and it needs the bus
  logic cap_alu;   // ... and it completes immediately
  logic ack_done;  // bus access completes this edge
  logic tmo_done;  // bus access aborted this edge
  logic tmo_expire;

  // The ALU keeps exe_mem high while stalled, so gating capture on
  // !mem_blocked is what prevents a double capture.
  assign mem_blocked = (state == BUS) || (wb_valid && wb_blocked);

  // ------------------------------------------------------------------
  // Sequencer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap       = exe_mem && !mem_blocked;
    cap_mem   = cap && is_mem_access(mem_op);
    cap_alu   = cap && !is_mem_access(mem_op);
    ack_done  = 1'b0;
    tmo_done  = 1'b0;
    case (state)
      IDLE: begin
        // bus_ack is ignored here; only a capture moves us on.
        if (cap_mem) begin
          state_nxt = BUS;
        end
      end
      BUS: begin
        // An ack on the expiry cycle still wins over the abort.
        if (bus_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_expire) begin
          tmo_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Bus request registers: loaded on capture, held until completion.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      lat_rflags <= '0;
      lat_dst    <= '0;
    end else if (cap_mem) begin
      bus_req    <= 1'b1;
      bus_we     <= (mem_op == MEM_STORE);
      bus_addr   <= alu_result;
      bus_wdata  <= store_data;
      lat_rflags <= alu_rflags;
      lat_dst    <= dst_reg;
    end else if (ack_done || tmo_done) begin
      bus_req    <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Writeback slot. A completing entry overwrites a draining one; a
  // stalled entry is never overwritten because nothing can complete
  // while wb_valid && wb_blocked (capture is blocked and no bus access
  // can be outstanding).
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_data   <= '0;
      wb_rflags <= '0;
      wb_dst    <= '0;
    end else if (cap_alu) begin
      wb_valid  <= 1'b1;
      wb_we     <= 1'b1;
      wb_data   <= alu_result;
      wb_rflags <= alu_rflags;
      wb_dst    <= dst_reg;
    end else if (ack_done) begin
      wb_valid  <= 1'b1;
      wb_we     <= !bus_we;
      wb_data   <= bus_we ? bus_wdata : bus_rdata;
      wb_rflags <= lat_rflags;
      wb_dst    <= lat_dst;
    end else if (tmo_done) begin
      // Aborted access: no register write; the faulting address is
      // reported in wb_data for whoever handles the error flag.
      wb_valid  <= 1'b1;
      wb_we     <= 1'b0;
      wb_data   <= bus_addr;
      wb_rflags <= lat_rflags | (32'h1 << MEM_ERR_FLAG_BIT);
      wb_dst    <= lat_dst;
    end else if (wb_valid && !wb_blocked) begin
      wb_valid  <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Optional bus-wait timeout
  // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cap),
    .count  (state == BUS),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= tmo_done;
    end
  end
`else
  // Without the watchdog the stage waits for bus_ack indefinitely.
  assign tmo_expire = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a randomized run against a transaction-level model.
module tb_mem_stage;

  localparam int DATA_W = 64;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              exe_mem;
  logic [DATA_W-1:0] alu_result;
  logic [31:0]       alu_rflags;
  logic [1:0]        mem_op;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  dst_reg;
  logic              mem_blocked;
  logic              bus_req;
  logic              bus_we;
  logic [DATA_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              wb_valid;
  logic              wb_we;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       wb_rflags;
  logic [REG_W-1:0]  wb_dst;
  logic              wb_blocked;
`ifdef MEM_TIMEOUT_EN
  logic              bus_err;
`endif

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYC (8)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .exe_mem     (exe_mem),
    .alu_result  (alu_result),
    .alu_rflags  (alu_rflags),
    .mem_op      (mem_op),
    .store_data  (store_data),
    .dst_reg     (dst_reg),
    .mem_blocked (mem_blocked),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .wb_valid    (wb_valid),
    .wb_we       (wb_we),
    .wb_data     (wb_data),
    .wb_rflags   (wb_rflags),
    .wb_dst      (wb_dst),
    .wb_blocked  (wb_blocked)
`ifdef MEM_TIMEOUT_EN
    , .bus_err   (bus_err)
`endif
  );

  // One writeback handoff as seen by the register file.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] data;
    logic [31:0]       flags;
    logic [REG_W-1:0]  dst;
  } wb_ent_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic wb_ent_t cur_wb();
    return {wb_we, wb_data, wb_rflags, wb_dst};
  endfunction

  // Transaction-level reference model state for the random run.
  wb_ent_t           exp_q[$];     // handoffs owed to writeback, in order
  wb_ent_t           snap;
  wb_ent_t           got;
  wb_ent_t           want;
  bit                frozen_m;
  bit                bus_busy_m;   // a load/store has been accepted and not yet acked
  bit                alu_vld_m;    // the ALU is presenting an instruction
  bit                blocked_m;
  bit                inf_store;
  logic [DATA_W-1:0] inf_addr;
  logic [DATA_W-1:0] inf_wdata;
  logic [31:0]       inf_flags;
  logic [REG_W-1:0]  inf_dst;
  int                ack_wait;

  initial begin
    reset      = 1'b1;
    exe_mem    = 1'b0;
    alu_result = '0;
    alu_rflags = '0;
    mem_op     = 2'd0;
    store_data = '0;
    dst_reg    = '0;
    bus_ack    = 1'b0;
    bus_rdata  = '0;
    wb_blocked = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_data", wb_data, 64'h0);
    check("rst_wb_rflags", wb_rflags, 32'h0);
    check("rst_wb_dst", wb_dst, 4'h0);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 64'h0);
    check("rst_bus_wdata", bus_wdata, 64'h0);
    check("rst_mem_blocked", mem_blocked, 1'b0);
    reset = 1'b0;
    tick();

    // ---------------- plain ALU op ----------------
    exe_mem = 1'b1; mem_op = 2'd0; alu_result = 64'h1234;
    alu_rflags = 32'h0000_00A5; dst_reg = 4'd3;
    tick();
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_data", wb_data, 64'h1234);
    check("alu_wb_we", wb_we, 1'b1);
    check("alu_wb_dst", wb_dst, 4'd3);
    check("alu_wb_rflags", wb_rflags, 32'h0000_00A5);
    check("alu_mem_blocked", mem_blocked, 1'b0);
    check("alu_bus_req", bus_req, 1'b0);
    exe_mem = 1'b0;
    tick();
    check("alu_drain", wb_valid, 1'b0);

    // ---------------- load, ack in third bus cycle ----------------
    exe_mem = 1'b1; mem_op = 2'd1; alu_result = 64'h1000;
    alu_rflags = 32'h0000_0011; dst_reg = 4'd5;
    tick();
    exe_mem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ld_bus_req", bus_req, 1'b1);
      check("ld_bus_addr", bus_addr, 64'h1000);
      check("ld_bus_we", bus_we, 1'b0);
      check("ld_mem_blocked", mem_blocked, 1'b1);
      check("ld_wb_idle", wb_valid, 1'b0);
      if (i == 2) begin
        bus_ack = 1'b1; bus_rdata = 64'hDEAD_BEEF;
      end
      tick();
    end
    bus_ack = 1'b0;
    check("ld_req_drop", bus_req, 1'b0);
    check("ld_wb_valid", wb_valid, 1'b1);
    check("ld_wb_data", wb_data, 64'hDEAD_BEEF);
    check("ld_wb_we", wb_we, 1'b1);
    check("ld_wb_dst", wb_dst, 4'd5);
    check("ld_wb_rflags", wb_rflags, 32'h0000_0011);
    check("ld_unblocked", mem_blocked, 1'b0);
    tick();

    // ---------------- store, ack in first bus cycle ----------------
    exe_mem = 1'b1; mem_op = 2'd2; alu_result = 64'h2000;
    store_data = 64'h55; alu_rflags = 32'h0000_0022; dst_reg = 4'd7;
    tick();
    exe_mem = 1'b0;
    check("st_bus_req", bus_req, 1'b1);
    check("st_bus_we", bus_we, 1'b1);
    check("st_bus_wdata", bus_wdata, 64'h55);
    check("st_bus_addr", bus_addr, 64'h2000);
    bus_ack = 1'b1; bus_rdata = 64'hFFFF;
    tick();
    bus_ack = 1'b0;
    check("st_req_drop", bus_req, 1'b0);
    check("st_wb_valid", wb_valid, 1'b1);
    check("st_wb_we", wb_we, 1'b0);
    check("st_wb_data", wb_data, 64'h55);
    check("st_wb_dst", wb_dst, 4'd7);
    tick();

    // ---------------- writeback back-pressure ----------------
    exe_mem = 1'b1; mem_op = 2'd0; alu_result = 64'hAAAA;
    alu_rflags = 32'h1; dst_reg = 4'd1;
    tick();
    check("bp_first", wb_data, 64'hAAAA);
    wb_blocked = 1'b1;
    alu_result = 64'hBBBB; alu_rflags = 32'h2; dst_reg = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_hold_valid", wb_valid, 1'b1);
      check("bp_hold_data", wb_data, 64'hAAAA);
      check("bp_hold_dst", wb_dst, 4'd1);
      check("bp_mem_blocked", mem_blocked, 1'b1);
    end
    wb_blocked = 1'b0;
    tick();
    exe_mem = 1'b0;
    check("bp_second_valid", wb_valid, 1'b1);
    check("bp_second_data", wb_data, 64'hBBBB);
    check("bp_second_dst", wb_dst, 4'd2);
    tick();
    check("bp_no_dup", wb_valid, 1'b0);

    // ---------------- reset during a bus access ----------------
    exe_mem = 1'b1; mem_op = 2'd1; alu_result = 64'h3000; dst_reg = 4'd4;
    tick();
    exe_mem = 1'b0;
    tick();
    check("rb_in_bus", bus_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rb_req_async", bus_req, 1'b0);
    check("rb_wb_async", wb_valid, 1'b0);
    check("rb_blk_async", mem_blocked, 1'b0);
    tick();
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 64'h9999;
    tick();
    bus_ack = 1'b0;
    check("rb_ack_ignored_wb", wb_valid, 1'b0);
    check("rb_ack_ignored_req", bus_req, 1'b0);
    tick();

`ifdef MEM_TIMEOUT_EN
    // ---------------- bus timeout (TIMEOUT_CYC = 8) ----------------
    exe_mem = 1'b1; mem_op = 2'd1; alu_result = 64'h4000;
    alu_rflags = 32'h0000_00F0; dst_reg = 4'd9;
    tick();
    exe_mem = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to_req_held", bus_req, 1'b1);
      check("to_no_err", bus_err, 1'b0);
      tick();
    end
    check("to_req_drop", bus_req, 1'b0);
    check("to_err_pulse", bus_err, 1'b1);
    check("to_wb_valid", wb_valid, 1'b1);
    check("to_wb_we", wb_we, 1'b0);
    check("to_wb_rflags", wb_rflags, 32'h8000_00F0);
    check("to_wb_dst", wb_dst, 4'd9);
    tick();
    check("to_err_end", bus_err, 1'b0);
    tick();
`endif

    check("pre_rand_idle", wb_valid, 1'b0);

    // ---------------- randomized run against the model ----------------
    bus_busy_m = 1'b0;
    alu_vld_m  = 1'b0;
    frozen_m   = 1'b0;
    ack_wait   = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(posedge clk);
      #1;
      // ALU: hold an unaccepted instruction, otherwise maybe issue a new one.
      if (!alu_vld_m && cyc < 1500 && $urandom_range(0, 2) != 0) begin
        alu_vld_m  = 1'b1;
        mem_op     = 2'($urandom_range(0, 3));
        alu_result = {$urandom, $urandom};
        alu_rflags = $urandom;
        store_data = {$urandom, $urandom};
        dst_reg    = 4'($urandom_range(0, 15));
      end
      exe_mem    = alu_vld_m;
      wb_blocked = ($urandom_range(0, 3) == 0);
      bus_rdata  = {$urandom, $urandom};
      if (bus_busy_m) begin
        bus_ack = (ack_wait == 0);
        if (ack_wait > 0) ack_wait--;
      end else begin
        bus_ack = ($urandom_range(0, 4) == 0);  // stray acks must be ignored
      end

      @(negedge clk);
      check("r_wb_count", wb_valid, (exp_q.size() != 0));
      if (frozen_m) check("r_wb_frozen", cur_wb(), snap);
      blocked_m = bus_busy_m || (exp_q.size() != 0 && wb_blocked);
      check("r_mem_blocked", mem_blocked, blocked_m);
      check("r_bus_req", bus_req, bus_busy_m);
      if (bus_busy_m) begin
        check("r_bus_addr", bus_addr, inf_addr);
        check("r_bus_we", bus_we, inf_store);
        if (inf_store) check("r_bus_wdata", bus_wdata, inf_wdata);
      end
`ifdef MEM_TIMEOUT_EN
      check("r_no_err", bus_err, 1'b0);
`endif
      // Effects of the coming edge, in handoff order.
      if (exp_q.size() != 0 && !wb_blocked) begin
        want = exp_q.pop_front();
        got  = cur_wb();
        check("r_wb_entry", got, want);
      end
      frozen_m = (exp_q.size() != 0) && wb_blocked;
      snap     = cur_wb();
      if (bus_busy_m && bus_ack) begin
        exp_q.push_back({!inf_store, inf_store ? inf_wdata : bus_rdata, inf_flags, inf_dst});
        bus_busy_m = 1'b0;
      end
      if (alu_vld_m && !blocked_m) begin
        alu_vld_m = 1'b0;
        if (mem_op == 2'd1 || mem_op == 2'd2) begin
          bus_busy_m = 1'b1;
          inf_store  = (mem_op == 2'd2);
          inf_addr   = alu_result;
          inf_wdata  = store_data;
          inf_flags  = alu_rflags;
          inf_dst    = dst_reg;
          ack_wait   = $urandom_range(0, 3);
        end else begin
          exp_q.push_back({1'b1, alu_result, alu_rflags, dst_reg});
        end
      end
    end
    check("r_all_drained", exp_q.size(), 0);
    check("r_alu_drained", alu_vld_m, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
